// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory port arbiter
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DATA = 1'b1} owner_t;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of data grants that fetch has lost
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int W = $clog2(STARVE_LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(STARVE_LIMIT);
  logic [W-1:0] cnt;
  assign at_limit = cnt == LIM;
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_limit) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with
// registered IDLE/ACCESS/RESP transactions and a fetch anti-starvation limit
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_command,
  output logic              busy,
  output logic              owner
);
  arb_state_t state, state_nx;
  logic we, any_req, grant_d, we_sel, at_limit, starve_inc, starve_clr;
  always_comb begin
    any_req    = if_req || d_req;
    grant_d    = d_req && !(if_req && at_limit);
    we_sel     = grant_d && d_we;
    starve_inc = state == ARB_IDLE && grant_d && if_req;
    starve_clr = state == ARB_IDLE && any_req && !grant_d;
    state_nx   = state == ARB_IDLE   ? (any_req ? ARB_ACCESS : ARB_IDLE) :
                 state == ARB_ACCESS ? ARB_RESP : ARB_IDLE;
  end
  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk), .rst(rst), .inc(starve_inc), .clr(starve_clr), .at_limit(at_limit)
  );
  // Address/data are latched at grant and held through RESP so they never move around a strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ARB_IDLE;
      we             <= 1'b0;
      owner          <= OWN_IF;
      busy           <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      if_ack         <= 1'b0;
      d_ack          <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
    end else begin
      state     <= state_nx;
      busy      <= state_nx != ARB_IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if (state == ARB_IDLE && any_req) begin
        owner          <= grant_d ? OWN_DATA : OWN_IF;
        we             <= we_sel;
        mem_address    <= grant_d ? d_addr : if_addr;
        mem_write_data <= grant_d ? d_wdata : mem_write_data;
        mem_read       <= !we_sel;
        mem_write      <= we_sel;
      end
      if (state == ARB_ACCESS) begin
        if_ack <= owner == OWN_IF;
        d_ack  <= owner == OWN_DATA;
        if (!we && owner == OWN_IF) if_rdata <= mem_command;
        if (!we && owner == OWN_DATA) d_rdata <= mem_command;
      end
    end
  end
endmodule
